lnrv_biu_arb: RTL and testbench

Two-master to one-slave bus arbiter that shares the core's single memory command/response port between the instruction fetch unit (master 0) and the load/store unit (master 1). It grants the command channel round-robin and records the owner of every accepted command in an in-order owner FIFO. It then routes each slave response back to the master that issued the matching command. It sits between the IFU/LSU command interfaces and the memory/bus interface.

---
 rtl/lnrv_biu_arb_pkg.sv | 14 +
 rtl/lnrv_biu_ots_fifo.sv | 51 +++++
 rtl/lnrv_biu_arb.sv | 98 +++++++++
 tb/tb_lnrv_biu_arb.sv | 308 ++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/lnrv_biu_arb_pkg.sv
// lnrv_biu_arb_pkg: master ids and the command payload bundle shared by the BIU arbiter files.
package lnrv_biu_arb_pkg;

    localparam logic LNRV_BIU_ID_IFU = 1'b0;
    localparam logic LNRV_BIU_ID_LSU = 1'b1;

    typedef struct packed {
        logic        write;
        logic [31:0] addr;
        logic [31:0] wdata;
        logic [3:0]  wstrb;
    } biu_cmd_t;

endpackage

// File: rtl/lnrv_biu_ots_fifo.sv
// lnrv_biu_ots_fifo: in-order owner FIFO of 1-bit master ids for accepted-but-unanswered commands.
//   clk, reset (sync, active-high); push/din enqueue, pop dequeue;
//   full/empty from the registered count; head = id at the read pointer.
module lnrv_biu_ots_fifo #(
    parameter int P_DEPTH = 2
) (
    input  logic clk,
    input  logic reset,
    input  logic push,
    input  logic din,
    input  logic pop,
    output logic full,
    output logic empty,
    output logic head
);

    localparam int PW = P_DEPTH > 1 ? $clog2(P_DEPTH) : 1;
    localparam int CW = $clog2(P_DEPTH + 1);

    logic [P_DEPTH-1:0] mem;
    logic [PW-1:0]      wr_ptr, rd_ptr;
    logic [CW-1:0]      cnt;
    logic               do_push, do_pop;

    function automatic logic [PW-1:0] nxt(input logic [PW-1:0] p);
        return (p == PW'(P_DEPTH - 1)) ? '0 : p + 1'b1;
    endfunction

    assign full    = cnt == CW'(P_DEPTH);
    assign empty   = cnt == '0;
    assign head    = mem[rd_ptr];
    assign do_push = push & ~full;
    assign do_pop  = pop & ~empty;

    always_ff @(posedge clk) begin
        if (reset) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            cnt    <= '0;
        end else begin
            if (do_push) wr_ptr <= nxt(wr_ptr);
            if (do_pop) rd_ptr <= nxt(rd_ptr);
            cnt <= cnt + CW'(do_push) - CW'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr] <= din;
    end

endmodule

// File: rtl/lnrv_biu_arb.sv
// lnrv_biu_arb: round-robin arbiter sharing one slave command/response port between IFU (m0) and LSU (m1).
//   clk, reset (sync, active-high)
//   m0_cmd_* / m1_cmd_*: master command channels (vld/rdy/write/addr/wdata/wstrb)
//   m0_rsp_* / m1_rsp_*: master response channels (vld/rdy/rdata/err)
//   s_cmd_* / s_rsp_*  : slave command and response channels
module lnrv_biu_arb
    import lnrv_biu_arb_pkg::*;
#(
    parameter int P_OTS_DEPTH = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        m0_cmd_vld,
    output logic        m0_cmd_rdy,
    input  logic        m0_cmd_write,
    input  logic [31:0] m0_cmd_addr,
    input  logic [31:0] m0_cmd_wdata,
    input  logic [3:0]  m0_cmd_wstrb,
    input  logic        m1_cmd_vld,
    output logic        m1_cmd_rdy,
    input  logic        m1_cmd_write,
    input  logic [31:0] m1_cmd_addr,
    input  logic [31:0] m1_cmd_wdata,
    input  logic [3:0]  m1_cmd_wstrb,
    output logic        m0_rsp_vld,
    input  logic        m0_rsp_rdy,
    output logic [31:0] m0_rsp_rdata,
    output logic        m0_rsp_err,
    output logic        m1_rsp_vld,
    input  logic        m1_rsp_rdy,
    output logic [31:0] m1_rsp_rdata,
    output logic        m1_rsp_err,
    output logic        s_cmd_vld,
    input  logic        s_cmd_rdy,
    output logic        s_cmd_write,
    output logic [31:0] s_cmd_addr,
    output logic [31:0] s_cmd_wdata,
    output logic [3:0]  s_cmd_wstrb,
    input  logic        s_rsp_vld,
    output logic        s_rsp_rdy,
    input  logic [31:0] s_rsp_rdata,
    input  logic        s_rsp_err
);

    logic     rr_last, lock, lock_id;
    logic     gnt_id, gnt_vld, cmd_hs, rsp_hs;
    logic     ots_full, ots_empty, ots_head;
    biu_cmd_t cmd0, cmd1;

    // Locked grant keeps the payload presented to the slave stable until it is taken.
    assign gnt_id  = lock ? lock_id : (m0_cmd_vld & m1_cmd_vld) ? ~rr_last : m1_cmd_vld;
    assign gnt_vld = gnt_id ? m1_cmd_vld : m0_cmd_vld;

    assign cmd0 = {m0_cmd_write, m0_cmd_addr, m0_cmd_wdata, m0_cmd_wstrb};
    assign cmd1 = {m1_cmd_write, m1_cmd_addr, m1_cmd_wdata, m1_cmd_wstrb};
    assign {s_cmd_write, s_cmd_addr, s_cmd_wdata, s_cmd_wstrb} = gnt_id ? cmd1 : cmd0;

    // Full is taken from the registered count so no response-to-command path exists.
    assign s_cmd_vld  = gnt_vld & ~ots_full;
    assign m0_cmd_rdy = ~gnt_id & s_cmd_rdy & ~ots_full;
    assign m1_cmd_rdy = gnt_id & s_cmd_rdy & ~ots_full;
    assign cmd_hs     = s_cmd_vld & s_cmd_rdy;

    assign s_rsp_rdy    = ~ots_empty & (ots_head ? m1_rsp_rdy : m0_rsp_rdy);
    assign m0_rsp_vld   = s_rsp_vld & ~ots_empty & ~ots_head;
    assign m1_rsp_vld   = s_rsp_vld & ~ots_empty & ots_head;
    assign m0_rsp_rdata = s_rsp_rdata;
    assign m1_rsp_rdata = s_rsp_rdata;
    assign m0_rsp_err   = s_rsp_err;
    assign m1_rsp_err   = s_rsp_err;
    assign rsp_hs       = s_rsp_vld & s_rsp_rdy;

    always_ff @(posedge clk) begin
        if (reset) begin
            rr_last <= LNRV_BIU_ID_LSU;
            lock    <= 1'b0;
            lock_id <= LNRV_BIU_ID_IFU;
        end else if (cmd_hs) begin
            rr_last <= gnt_id;
            lock    <= 1'b0;
        end else if (gnt_vld) begin
            lock    <= 1'b1;
            lock_id <= gnt_id;
        end
    end

    lnrv_biu_ots_fifo #(.P_DEPTH(P_OTS_DEPTH)) u_ots_fifo (
        .clk   (clk),
        .reset (reset),
        .push  (cmd_hs),
        .din   (gnt_id),
        .pop   (rsp_hs),
        .full  (ots_full),
        .empty (ots_empty),
        .head  (ots_head)
    );

endmodule

// File: tb/tb_lnrv_biu_arb.sv
// tb_lnrv_biu_arb: directed scenarios plus a randomized run against a queue-based arbitration model.
module tb_lnrv_biu_arb;

    localparam int DEPTH = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        m0_cmd_vld, m0_cmd_rdy, m0_cmd_write;
    logic [31:0] m0_cmd_addr, m0_cmd_wdata;
    logic [3:0]  m0_cmd_wstrb;
    logic        m1_cmd_vld, m1_cmd_rdy, m1_cmd_write;
    logic [31:0] m1_cmd_addr, m1_cmd_wdata;
    logic [3:0]  m1_cmd_wstrb;
    logic        m0_rsp_vld, m0_rsp_rdy, m0_rsp_err;
    logic [31:0] m0_rsp_rdata;
    logic        m1_rsp_vld, m1_rsp_rdy, m1_rsp_err;
    logic [31:0] m1_rsp_rdata;
    logic        s_cmd_vld, s_cmd_rdy, s_cmd_write;
    logic [31:0] s_cmd_addr, s_cmd_wdata;
    logic [3:0]  s_cmd_wstrb;
    logic        s_rsp_vld, s_rsp_rdy, s_rsp_err;
    logic [31:0] s_rsp_rdata;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    lnrv_biu_arb #(.P_OTS_DEPTH(DEPTH)) dut (
        .clk(clk), .reset(reset),
        .m0_cmd_vld(m0_cmd_vld), .m0_cmd_rdy(m0_cmd_rdy), .m0_cmd_write(m0_cmd_write),
        .m0_cmd_addr(m0_cmd_addr), .m0_cmd_wdata(m0_cmd_wdata), .m0_cmd_wstrb(m0_cmd_wstrb),
        .m1_cmd_vld(m1_cmd_vld), .m1_cmd_rdy(m1_cmd_rdy), .m1_cmd_write(m1_cmd_write),
        .m1_cmd_addr(m1_cmd_addr), .m1_cmd_wdata(m1_cmd_wdata), .m1_cmd_wstrb(m1_cmd_wstrb),
        .m0_rsp_vld(m0_rsp_vld), .m0_rsp_rdy(m0_rsp_rdy), .m0_rsp_rdata(m0_rsp_rdata), .m0_rsp_err(m0_rsp_err),
        .m1_rsp_vld(m1_rsp_vld), .m1_rsp_rdy(m1_rsp_rdy), .m1_rsp_rdata(m1_rsp_rdata), .m1_rsp_err(m1_rsp_err),
        .s_cmd_vld(s_cmd_vld), .s_cmd_rdy(s_cmd_rdy), .s_cmd_write(s_cmd_write),
        .s_cmd_addr(s_cmd_addr), .s_cmd_wdata(s_cmd_wdata), .s_cmd_wstrb(s_cmd_wstrb),
        .s_rsp_vld(s_rsp_vld), .s_rsp_rdy(s_rsp_rdy), .s_rsp_rdata(s_rsp_rdata), .s_rsp_err(s_rsp_err)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic idle_inputs;
        m0_cmd_vld = 0; m0_cmd_write = 0; m0_cmd_addr = 0; m0_cmd_wdata = 0; m0_cmd_wstrb = 0;
        m1_cmd_vld = 0; m1_cmd_write = 0; m1_cmd_addr = 0; m1_cmd_wdata = 0; m1_cmd_wstrb = 0;
        m0_rsp_rdy = 1; m1_rsp_rdy = 1; s_cmd_rdy = 0;
        s_rsp_vld = 0; s_rsp_rdata = 0; s_rsp_err = 0;
    endtask

    task automatic do_reset;
        idle_inputs();
        reset = 1;
        tick();
        tick();
        reset = 0;
    endtask

    task automatic test_reset;
        idle_inputs();
        reset = 1;
        s_rsp_vld = 1;
        tick();
        #1;
        checks++; if (s_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rst_s_rsp_rdy got %b exp 0", s_rsp_rdy); end
        checks++; if ({m0_rsp_vld, m1_rsp_vld} !== 2'b00) begin errors++; $display("FAIL rst_rsp_vld got %b exp 00", {m0_rsp_vld, m1_rsp_vld}); end
        checks++; if (s_cmd_vld !== 1'b0) begin errors++; $display("FAIL rst_s_cmd_vld got %b exp 0", s_cmd_vld); end
        reset = 0;
        tick();
        m0_cmd_vld = 1;
        s_cmd_rdy = 1;
        #1;
        checks++; if ({s_cmd_vld, m0_cmd_rdy, m1_cmd_rdy} !== 3'b110) begin errors++; $display("FAIL rst_idle_winner got %b exp 110", {s_cmd_vld, m0_cmd_rdy, m1_cmd_rdy}); end
        checks++; if (s_rsp_rdy !== 1'b0) begin errors++; $display("FAIL rst_empty_rsp_rdy got %b exp 0", s_rsp_rdy); end
        s_cmd_rdy = 0;
        #1;
        checks++; if (m0_cmd_rdy !== 1'b0) begin errors++; $display("FAIL rst_cmd_rdy_follow got %b exp 0", m0_cmd_rdy); end
        idle_inputs();
        tick();
    endtask

    task automatic test_single;
        do_reset();
        m0_cmd_vld = 1; m0_cmd_addr = 32'h8000_0000; s_cmd_rdy = 1;
        #1;
        checks++; if (s_cmd_addr !== 32'h8000_0000) begin errors++; $display("FAIL single_addr got %h exp 80000000", s_cmd_addr); end
        checks++; if ({s_cmd_vld, m0_cmd_rdy, m1_cmd_rdy} !== 3'b110) begin errors++; $display("FAIL single_hs got %b exp 110", {s_cmd_vld, m0_cmd_rdy, m1_cmd_rdy}); end
        tick();
        m0_cmd_vld = 0; s_rsp_vld = 1; s_rsp_rdata = 32'h0000_0013;
        #1;
        checks++; if ({m0_rsp_vld, m1_rsp_vld, s_rsp_rdy} !== 3'b101) begin errors++; $display("FAIL single_rsp_route got %b exp 101", {m0_rsp_vld, m1_rsp_vld, s_rsp_rdy}); end
        checks++; if (m0_rsp_rdata !== 32'h0000_0013) begin errors++; $display("FAIL single_rdata got %h exp 00000013", m0_rsp_rdata); end
        tick();
        #1;
        checks++; if ({m0_rsp_vld, m1_rsp_vld, s_rsp_rdy} !== 3'b000) begin errors++; $display("FAIL single_after_pop got %b exp 000", {m0_rsp_vld, m1_rsp_vld, s_rsp_rdy}); end
        idle_inputs();
    endtask

    task automatic test_fair;
        do_reset();
        m0_cmd_addr = 32'h0000_1000; m1_cmd_addr = 32'h0000_2000; s_cmd_rdy = 1;
        for (int i = 0; i < 5; i++) begin
            m0_cmd_vld = (i < 4); m1_cmd_vld = (i < 4);
            s_rsp_vld = (i > 0); s_rsp_rdata = i;
            #1;
            if (i < 4) begin
                checks++;
                if (s_cmd_addr !== ((i % 2) ? 32'h0000_2000 : 32'h0000_1000)) begin
                    errors++; $display("FAIL fair_grant[%0d] got %h exp %h", i, s_cmd_addr, (i % 2) ? 32'h0000_2000 : 32'h0000_1000);
                end
            end
            if (i > 0) begin
                checks++;
                if ({m0_rsp_vld, m1_rsp_vld} !== (((i - 1) % 2) ? 2'b01 : 2'b10)) begin
                    errors++; $display("FAIL fair_rsp[%0d] got %b exp %b", i, {m0_rsp_vld, m1_rsp_vld}, ((i - 1) % 2) ? 2'b01 : 2'b10);
                end
            end
            tick();
        end
        idle_inputs();
    endtask

    task automatic test_lock;
        do_reset();
        m1_cmd_vld = 1; m1_cmd_addr = 32'hB000_0004; m1_cmd_wdata = 32'hCAFE_F00D; m1_cmd_write = 1; m1_cmd_wstrb = 4'hA;
        m0_cmd_addr = 32'hA000_0000;
        for (int i = 0; i < 3; i++) begin
            m0_cmd_vld = (i >= 1);
            #1;
            checks++;
            if ({s_cmd_write, s_cmd_addr, s_cmd_wdata, s_cmd_wstrb} !== {1'b1, 32'hB000_0004, 32'hCAFE_F00D, 4'hA}) begin
                errors++; $display("FAIL lock_hold[%0d] got %h/%h exp B0000004/CAFEF00D", i, s_cmd_addr, s_cmd_wdata);
            end
            checks++; if ({m0_cmd_rdy, m1_cmd_rdy, s_cmd_vld} !== 3'b001) begin errors++; $display("FAIL lock_rdy[%0d] got %b exp 001", i, {m0_cmd_rdy, m1_cmd_rdy, s_cmd_vld}); end
            tick();
        end
        s_cmd_rdy = 1;
        #1;
        checks++; if ({m0_cmd_rdy, m1_cmd_rdy, s_cmd_addr} !== {2'b01, 32'hB000_0004}) begin errors++; $display("FAIL lock_release got %b/%h exp 01/B0000004", {m0_cmd_rdy, m1_cmd_rdy}, s_cmd_addr); end
        tick();
        m1_cmd_vld = 0;
        #1;
        checks++; if ({m0_cmd_rdy, m1_cmd_rdy, s_cmd_addr} !== {2'b10, 32'hA000_0000}) begin errors++; $display("FAIL lock_next_m0 got %b/%h exp 10/A0000000", {m0_cmd_rdy, m1_cmd_rdy}, s_cmd_addr); end
        tick();
        m0_cmd_vld = 0; s_rsp_vld = 1;
        #1;
        checks++; if ({m0_rsp_vld, m1_rsp_vld} !== 2'b01) begin errors++; $display("FAIL lock_rsp_first got %b exp 01", {m0_rsp_vld, m1_rsp_vld}); end
        tick();
        #1;
        checks++; if ({m0_rsp_vld, m1_rsp_vld} !== 2'b10) begin errors++; $display("FAIL lock_rsp_second got %b exp 10", {m0_rsp_vld, m1_rsp_vld}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_full;
        do_reset();
        m0_cmd_vld = 1; s_cmd_rdy = 1;
        for (int i = 0; i < 2; i++) begin
            m0_cmd_addr = 32'h100 + 4 * i;
            #1;
            checks++; if (m0_cmd_rdy !== 1'b1) begin errors++; $display("FAIL full_accept[%0d] got %b exp 1", i, m0_cmd_rdy); end
            tick();
        end
        m0_cmd_addr = 32'h108;
        #1;
        checks++; if ({m0_cmd_rdy, s_cmd_vld} !== 2'b00) begin errors++; $display("FAIL full_block got %b exp 00", {m0_cmd_rdy, s_cmd_vld}); end
        tick();
        s_rsp_vld = 1;
        #1;
        checks++; if ({s_rsp_rdy, m0_cmd_rdy, s_cmd_vld} !== 3'b100) begin errors++; $display("FAIL full_same_cycle got %b exp 100", {s_rsp_rdy, m0_cmd_rdy, s_cmd_vld}); end
        tick();
        s_rsp_vld = 0;
        #1;
        checks++; if ({m0_cmd_rdy, s_cmd_vld, s_cmd_addr} !== {2'b11, 32'h108}) begin errors++; $display("FAIL full_next_cycle got %b/%h exp 11/00000108", {m0_cmd_rdy, s_cmd_vld}, s_cmd_addr); end
        tick();
        m0_cmd_vld = 0; s_rsp_vld = 1;
        tick();
        tick();
        idle_inputs();
    endtask

    task automatic test_rsp_backpressure;
        do_reset();
        m0_cmd_vld = 1; m1_cmd_vld = 1; s_cmd_rdy = 1;
        tick();
        m0_cmd_vld = 0;
        tick();
        m1_cmd_vld = 0;
        s_rsp_vld = 1; s_rsp_rdata = 32'h55; m0_rsp_rdy = 0;
        for (int i = 0; i < 2; i++) begin
            #1;
            checks++; if ({s_rsp_rdy, m0_rsp_vld, m1_rsp_vld} !== 3'b010) begin errors++; $display("FAIL bp_stall[%0d] got %b exp 010", i, {s_rsp_rdy, m0_rsp_vld, m1_rsp_vld}); end
            tick();
        end
        m0_rsp_rdy = 1;
        #1;
        checks++; if ({s_rsp_rdy, m0_rsp_vld, m1_rsp_vld} !== 3'b110) begin errors++; $display("FAIL bp_release got %b exp 110", {s_rsp_rdy, m0_rsp_vld, m1_rsp_vld}); end
        tick();
        #1;
        checks++; if ({s_rsp_rdy, m0_rsp_vld, m1_rsp_vld} !== 3'b101) begin errors++; $display("FAIL bp_m1_after got %b exp 101", {s_rsp_rdy, m0_rsp_vld, m1_rsp_vld}); end
        tick();
        idle_inputs();
    endtask

    task automatic test_reset_mid;
        do_reset();
        m1_cmd_vld = 1; m0_cmd_addr = 32'h0000_0A00; m1_cmd_addr = 32'h0000_0B00; s_cmd_rdy = 1;
        tick();
        m1_cmd_vld = 0; m0_cmd_vld = 1;
        tick();
        m0_cmd_vld = 0;
        reset = 1;
        tick();
        reset = 0; s_rsp_vld = 1;
        #1;
        checks++; if ({s_rsp_rdy, m0_rsp_vld, m1_rsp_vld} !== 3'b000) begin errors++; $display("FAIL mid_rst_rsp got %b exp 000", {s_rsp_rdy, m0_rsp_vld, m1_rsp_vld}); end
        s_rsp_vld = 0; m0_cmd_vld = 1; m1_cmd_vld = 1;
        #1;
        checks++; if ({m0_cmd_rdy, m1_cmd_rdy, s_cmd_vld, s_cmd_addr} !== {3'b101, 32'h0000_0A00}) begin errors++; $display("FAIL mid_rst_grant got %b/%h exp 101/00000A00", {m0_cmd_rdy, m1_cmd_rdy, s_cmd_vld}, s_cmd_addr); end
        idle_inputs();
        do_reset();
    endtask

    task automatic test_random;
        int          q[$];
        int          last, held, g;
        logic        pend[2];
        logic        wr[2];
        logic [31:0] ad[2], wd[2];
        logic [3:0]  st[2];
        logic        rr[2];
        logic        gv, nf, ecv, ers, cmd_hs, rsp_hs;
        int          h;
        do_reset();
        last = 1; held = -1;
        pend[0] = 0; pend[1] = 0;
        for (int c = 0; c < 3000; c++) begin
            for (int m = 0; m < 2; m++) begin
                if (!pend[m] && $urandom_range(1, 0) == 1) begin
                    pend[m] = 1; wr[m] = 1'($urandom); ad[m] = $urandom; wd[m] = $urandom; st[m] = 4'($urandom);
                end
                rr[m] = $urandom_range(3, 0) != 0;
            end
            m0_cmd_vld = pend[0]; m0_cmd_write = wr[0]; m0_cmd_addr = ad[0]; m0_cmd_wdata = wd[0]; m0_cmd_wstrb = st[0];
            m1_cmd_vld = pend[1]; m1_cmd_write = wr[1]; m1_cmd_addr = ad[1]; m1_cmd_wdata = wd[1]; m1_cmd_wstrb = st[1];
            m0_rsp_rdy = rr[0]; m1_rsp_rdy = rr[1];
            s_cmd_rdy = $urandom_range(3, 0) != 0;
            s_rsp_vld = $urandom_range(1, 0) == 1;
            s_rsp_rdata = $urandom; s_rsp_err = 1'($urandom);
            g   = (held >= 0) ? held : (pend[0] && pend[1]) ? 1 - last : pend[1] ? 1 : 0;
            gv  = pend[g];
            nf  = q.size() < DEPTH;
            ecv = gv && nf;
            h   = (q.size() > 0) ? q[0] : 0;
            ers = (q.size() > 0) && rr[h];
            #1;
            checks++; if (s_cmd_vld !== ecv) begin errors++; $display("FAIL rnd_s_cmd_vld c=%0d got %b exp %b", c, s_cmd_vld, ecv); end
            if (gv) begin
                checks++;
                if ({s_cmd_write, s_cmd_addr, s_cmd_wdata, s_cmd_wstrb} !== {wr[g], ad[g], wd[g], st[g]}) begin
                    errors++; $display("FAIL rnd_payload c=%0d got %h exp %h (m%0d)", c, s_cmd_addr, ad[g], g);
                end
                checks++;
                if ({m0_cmd_rdy, m1_cmd_rdy} !== {g == 0 && s_cmd_rdy && nf, g == 1 && s_cmd_rdy && nf}) begin
                    errors++; $display("FAIL rnd_cmd_rdy c=%0d got %b exp m%0d nf=%b", c, {m0_cmd_rdy, m1_cmd_rdy}, g, nf);
                end
            end
            checks++; if (s_rsp_rdy !== ers) begin errors++; $display("FAIL rnd_s_rsp_rdy c=%0d got %b exp %b", c, s_rsp_rdy, ers); end
            checks++;
            if ({m0_rsp_vld, m1_rsp_vld} !== {s_rsp_vld && q.size() > 0 && h == 0, s_rsp_vld && q.size() > 0 && h == 1}) begin
                errors++; $display("FAIL rnd_rsp_vld c=%0d got %b exp owner m%0d n=%0d", c, {m0_rsp_vld, m1_rsp_vld}, h, q.size());
            end
            checks++;
            if ({m0_rsp_rdata, m1_rsp_rdata, m0_rsp_err, m1_rsp_err} !== {s_rsp_rdata, s_rsp_rdata, s_rsp_err, s_rsp_err}) begin
                errors++; $display("FAIL rnd_rsp_data c=%0d got %h/%h exp %h", c, m0_rsp_rdata, m1_rsp_rdata, s_rsp_rdata);
            end
            cmd_hs = ecv && s_cmd_rdy;
            rsp_hs = s_rsp_vld && ers;
            tick();
            if (rsp_hs) void'(q.pop_front());
            if (cmd_hs) begin
                q.push_back(g); last = g; held = -1; pend[g] = 0;
            end else if (gv) begin
                held = g;
            end
        end
        idle_inputs();
    endtask

    initial begin
        reset = 1;
        idle_inputs();
        test_reset();
        test_single();
        test_fair();
        test_lock();
        test_full();
        test_rsp_backpressure();
        test_reset_mid();
        test_random();
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule
